// File: rtl/intc186.sv
// 80186-style interrupt controller (master, non-cascaded) for the Zet Wishbone I/O window 0xFF20-0xFF3E.
// Define INTC186_LEVEL_EN to build the per-source level-trigger (LTM) request path.
module intc186 #(
    parameter logic [7:0] SPUR_VEC = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        tmr_i,
    input  logic        dma0_i,
    input  logic        dma1_i,
    input  logic [3:0]  int_i,
    input  logic        inta_i,
    output logic        intr_o,
    output logic [7:0]  vec_o
);

    localparam logic [3:0] ADR_EOI     = 4'd1;
    localparam logic [3:0] ADR_POLL    = 4'd2;
    localparam logic [3:0] ADR_POLLSTS = 4'd3;
    localparam logic [3:0] ADR_MASK    = 4'd4;
    localparam logic [3:0] ADR_PRIMSK  = 4'd5;
    localparam logic [3:0] ADR_INSERV  = 4'd6;
    localparam logic [3:0] ADR_REQST   = 4'd7;
    localparam logic [3:0] ADR_TCUCON  = 4'd9;

    // Bit n of every 8-bit source vector has interrupt type 0x08+n; bit 1 has no source.
    logic [7:0] src, sync1, sync2, sync3, rise;
    logic [7:0] req, req_n, inserv, inserv_n, msk;
    logic [2:0] pr [8];
    logic [2:0] primsk;
    logic       inta_q, ack_d;

    logic       wb_acc, wr_lo, poll_rd, eoi, ack, ack_inta;
    logic       ctl_hit;
    logic [2:0] ctl_bit;
    logic [3:0] isr_min, win_pr;
    logic [2:0] isr_top, win_idx;
    logic       win_valid;
    logic [7:0] ack_set, eoi_clr;
    logic [15:0] poll_word, rd_data, ctl_word;
    logic       unused_dat;

`ifdef INTC186_LEVEL_EN
    logic [7:0] ltm;
`endif

    assign src      = {int_i, dma1_i, dma0_i, 1'b0, tmr_i};
    assign rise     = sync2 & ~sync3;

    assign wb_acc   = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_lo    = wb_acc & wb_we_i & wb_sel_i[0];
    assign poll_rd  = wb_acc & ~wb_we_i & (wb_adr_i == ADR_POLL);
    assign eoi      = wb_acc & wb_we_i & (wb_adr_i == ADR_EOI) & (&wb_sel_i);
    assign ack_inta = inta_i & ~inta_q;
    assign ack      = ack_inta | poll_rd;

    assign ctl_hit  = (wb_adr_i >= ADR_TCUCON);
    assign ctl_bit  = (wb_adr_i == ADR_TCUCON) ? 3'd0 : wb_adr_i[2:0];

    assign unused_dat = ^wb_dat_i[14:8];

    // Highest-priority in-service level; 8 means nothing is in service.
    always_comb begin
        isr_min = 4'd8;
        isr_top = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (inserv[i] && ({1'b0, pr[i]} < isr_min)) begin
                isr_min = {1'b0, pr[i]};
                isr_top = 3'(i);
            end
        end
    end

    // Strict compare keeps the lower bit index on PR ties (TMR > D0 > D1 > I0..I3).
    always_comb begin
        win_valid = 1'b0;
        win_pr    = 4'd8;
        win_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i] && !msk[i] && (pr[i] <= primsk) &&
                ({1'b0, pr[i]} < isr_min) && ({1'b0, pr[i]} < win_pr)) begin
                win_valid = 1'b1;
                win_pr    = {1'b0, pr[i]};
                win_idx   = 3'(i);
            end
        end
    end

    assign ack_set   = (ack && win_valid) ? (8'b1 << win_idx) : 8'h00;
    assign poll_word = {win_valid, 10'h000, win_valid ? {2'b01, win_idx} : 5'h00};

    always_comb begin
        eoi_clr = 8'h00;
        if (eoi) begin
            if (wb_dat_i[15]) begin
                if (!isr_min[3])
                    eoi_clr = 8'b1 << isr_top;
            end else if (wb_dat_i[4:3] == 2'b01 && wb_dat_i[2:0] != 3'd1) begin
                eoi_clr = 8'b1 << wb_dat_i[2:0];
            end
        end
    end

    always_comb begin
        inserv_n = inserv;
        if (wr_lo && wb_adr_i == ADR_INSERV)
            inserv_n = wb_dat_i[7:0] & 8'hFD;
        inserv_n = (inserv_n & ~eoi_clr) | ack_set;
    end

    always_comb begin
        req_n = (req & ~ack_set) | rise;
`ifdef INTC186_LEVEL_EN
        req_n = (req_n & ~ltm) | (sync2 & ltm);
`endif
    end

    always_comb begin
        ctl_word = {11'h000, 1'b0, msk[ctl_bit], pr[ctl_bit]};
`ifdef INTC186_LEVEL_EN
        ctl_word[4] = ltm[ctl_bit];
`endif
    end

    always_comb begin
        rd_data = 16'h0000;
        case (wb_adr_i)
            ADR_POLL, ADR_POLLSTS: rd_data = poll_word;
            ADR_MASK:              rd_data = {8'h00, msk & 8'hFD};
            ADR_PRIMSK:            rd_data = {13'h0000, primsk};
            ADR_INSERV:            rd_data = {8'h00, inserv};
            ADR_REQST:             rd_data = {8'h00, req};
            default:               rd_data = ctl_hit ? ctl_word : 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 8'h00;
            sync2    <= 8'h00;
            sync3    <= 8'h00;
            req      <= 8'h00;
            inserv   <= 8'h00;
            msk      <= 8'hFF;
            primsk   <= 3'd7;
            inta_q   <= 1'b0;
            ack_d    <= 1'b0;
            intr_o   <= 1'b0;
            vec_o    <= SPUR_VEC;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 16'h0000;
            for (int i = 0; i < 8; i++)
                pr[i] <= 3'd7;
`ifdef INTC186_LEVEL_EN
            ltm      <= 8'h00;
`endif
        end else begin
            sync1    <= src;
            sync2    <= sync1;
            sync3    <= sync2;
            req      <= req_n;
            inserv   <= inserv_n;
            inta_q   <= inta_i;
            ack_d    <= ack;
            // Hold intr_o low for two cycles after any acknowledge so the CPU sees a clean drop.
            intr_o   <= win_valid & ~ack & ~ack_d;
            wb_ack_o <= wb_acc;
            if (wb_acc)
                wb_dat_o <= wb_we_i ? 16'h0000 : rd_data;
            if (ack)
                vec_o <= win_valid ? {5'b00001, win_idx} : SPUR_VEC;
            if (wr_lo) begin
                if (wb_adr_i == ADR_MASK)
                    msk <= wb_dat_i[7:0] | 8'h02;
                if (wb_adr_i == ADR_PRIMSK)
                    primsk <= wb_dat_i[2:0];
                if (ctl_hit) begin
                    pr[ctl_bit]  <= wb_dat_i[2:0];
                    msk[ctl_bit] <= wb_dat_i[3];
`ifdef INTC186_LEVEL_EN
                    ltm[ctl_bit] <= wb_dat_i[4];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_intc186.sv
// Directed self-checking bench for intc186; level-mode steps run only when INTC186_LEVEL_EN is defined.
module tb_intc186;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wb_adr = 4'h0;
    logic [15:0] wb_dat_w = 16'h0000;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel = 2'b00;
    logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
    logic        wb_ack_o;
    logic        tmr_i = 1'b0, dma0_i = 1'b0, dma1_i = 1'b0;
    logic [3:0]  int_i = 4'h0;
    logic        inta_i = 1'b0;
    logic        intr_o;
    logic [7:0]  vec_o;

    int checks = 0;
    int failures = 0;
    logic [15:0] rd;

    always #5 clk = ~clk;

    intc186 dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel),
        .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack_o),
        .tmr_i(tmr_i), .dma0_i(dma0_i), .dma1_i(dma1_i), .int_i(int_i),
        .inta_i(inta_i), .intr_o(intr_o), .vec_o(vec_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
        wb_adr = a; wb_dat_w = d; wb_sel = s; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        tick();
        chk("wr_ack", 16'(wb_ack_o), 16'h0001);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        tick();
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [15:0] d);
        wb_adr = a; wb_sel = 2'b11; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        tick();
        chk("rd_ack", 16'(wb_ack_o), 16'h0001);
        d = wb_dat_o;
        wb_stb = 1'b0; wb_cyc = 1'b0;
        tick();
        chk("ack_pulse", 16'(wb_ack_o), 16'h0000);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ack", 16'(wb_ack_o), 16'h0000);
        chk("rst_dat", wb_dat_o, 16'h0000);
        chk("rst_intr", 16'(intr_o), 16'h0000);
        chk("rst_vec", {8'h00, vec_o}, 16'h0007);
        wb_read(4'd4, rd);  chk("rst_mask", rd, 16'h00FD);
        wb_read(4'd5, rd);  chk("rst_primsk", rd, 16'h0007);
        wb_read(4'd9, rd);  chk("rst_tcucon", rd, 16'h000F);

        // High lane alone does not reach the control byte
        wb_write(4'd12, 16'h0002, 2'b10);
        wb_read(4'd12, rd); chk("lane_hi_only", rd, 16'h000F);

        // INT0 edge: REQST at N+2, intr_o at N+3, then acknowledge
        wb_write(4'd12, 16'h0002, 2'b11);
        wb_read(4'd12, rd); chk("i0con", rd, 16'h0002);
        int_i[0] = 1'b1;
        wait_n(3);
        chk("i0_intr_n2", 16'(intr_o), 16'h0000);
        wb_read(4'd7, rd);  chk("i0_reqst_n2", rd, 16'h0010);
        chk("i0_intr_n3", 16'(intr_o), 16'h0001);
        int_i[0] = 1'b0;
        inta_i = 1'b1;
        tick();
        chk("i0_vec", {8'h00, vec_o}, 16'h000C);
        chk("i0_intr_m", 16'(intr_o), 16'h0000);
        tick();
        chk("i0_intr_m1", 16'(intr_o), 16'h0000);
        inta_i = 1'b0;
        wb_read(4'd6, rd);  chk("i0_inserv", rd, 16'h0010);
        wb_read(4'd7, rd);  chk("i0_reqst_clr", rd, 16'h0000);

        // Priority: I1 (PR1) beats TMR (PR3); TMR follows a specific EOI of type 0x0D
        do_reset();
        wb_write(4'd9, 16'h0003, 2'b11);
        wb_write(4'd13, 16'h0001, 2'b11);
        tmr_i = 1'b1; int_i[1] = 1'b1;
        wait_n(4);
        chk("pri_intr", 16'(intr_o), 16'h0001);
        inta_i = 1'b1;
        tick();
        chk("pri_vec_i1", {8'h00, vec_o}, 16'h000D);
        inta_i = 1'b0;
        wait_n(3);
        chk("pri_tmr_blocked", 16'(intr_o), 16'h0000);
        wb_write(4'd1, 16'h000D, 2'b11);
        chk("pri_tmr_intr", 16'(intr_o), 16'h0001);
        inta_i = 1'b1;
        tick();
        chk("pri_vec_tmr", {8'h00, vec_o}, 16'h0008);
        inta_i = 1'b0; tmr_i = 1'b0; int_i[1] = 1'b0;

        // Nesting: I2 in service at PR4 blocks I0 at PR5 until non-specific EOI
        do_reset();
        wb_write(4'd14, 16'h0004, 2'b11);
        wb_write(4'd12, 16'h0005, 2'b11);
        int_i[2] = 1'b1;
        wait_n(4);
        inta_i = 1'b1;
        tick();
        chk("nest_vec_i2", {8'h00, vec_o}, 16'h000E);
        inta_i = 1'b0; int_i[2] = 1'b0; int_i[0] = 1'b1;
        wait_n(5);
        chk("nest_blocked", 16'(intr_o), 16'h0000);
        wb_write(4'd1, 16'h8000, 2'b01);
        wait_n(2);
        chk("nest_eoi_one_lane", 16'(intr_o), 16'h0000);
        wb_write(4'd1, 16'h8000, 2'b11);
        chk("nest_i0_intr", 16'(intr_o), 16'h0001);
        wb_read(4'd6, rd);  chk("nest_inserv", rd, 16'h0000);
        int_i[0] = 1'b0;

        // PRIMSK blocks I3 at PR3, opening it releases the request
        do_reset();
        wb_write(4'd5, 16'h0002, 2'b11);
        wb_write(4'd15, 16'h0003, 2'b11);
        int_i[3] = 1'b1;
        wait_n(5);
        chk("pm_blocked", 16'(intr_o), 16'h0000);
        wb_read(4'd3, rd);  chk("pm_pollsts0", rd, 16'h0000);
        wb_write(4'd5, 16'h0007, 2'b11);
        wb_read(4'd3, rd);  chk("pm_pollsts", rd, 16'h800F);
        chk("pm_intr", 16'(intr_o), 16'h0001);

        // Reset while intr_o is high and a Wishbone read is pending
        wb_adr = 4'd7; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        rst = 1'b1; int_i[3] = 1'b0;
        tick();
        chk("mid_rst_intr", 16'(intr_o), 16'h0000);
        chk("mid_rst_ack", 16'(wb_ack_o), 16'h0000);
        chk("mid_rst_dat", wb_dat_o, 16'h0000);
        chk("mid_rst_vec", {8'h00, vec_o}, 16'h0007);
        wb_stb = 1'b0; wb_cyc = 1'b0;
        tick();
        rst = 1'b0;

        // POLL acknowledges D0; a second POLL finds nothing
        do_reset();
        wb_write(4'd10, 16'h0000, 2'b11);
        dma0_i = 1'b1;
        tick();
        dma0_i = 1'b0;
        wait_n(4);
        wb_read(4'd2, rd);  chk("poll_d0", rd, 16'h800A);
        chk("poll_vec", {8'h00, vec_o}, 16'h000A);
        wb_read(4'd6, rd);  chk("poll_inserv", rd, 16'h0004);
        wb_read(4'd2, rd);  chk("poll_empty", rd, 16'h0000);
        chk("poll_spur_vec", {8'h00, vec_o}, 16'h0007);
        chk("poll_intr", 16'(intr_o), 16'h0000);

`ifdef INTC186_LEVEL_EN
        // Level mode: held I0 re-requests after EOI, drop clears REQST
        do_reset();
        wb_write(4'd12, 16'h0012, 2'b11);
        wb_read(4'd12, rd); chk("lvl_i0con", rd, 16'h0012);
        int_i[0] = 1'b1;
        wait_n(4);
        chk("lvl_intr", 16'(intr_o), 16'h0001);
        inta_i = 1'b1;
        tick();
        chk("lvl_vec", {8'h00, vec_o}, 16'h000C);
        inta_i = 1'b0;
        wait_n(3);
        chk("lvl_in_service", 16'(intr_o), 16'h0000);
        wb_write(4'd1, 16'h8000, 2'b11);
        chk("lvl_reassert", 16'(intr_o), 16'h0001);
        int_i[0] = 1'b0;
        wait_n(3);
        wb_read(4'd7, rd);  chk("lvl_reqst_drop", rd, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intc186.md
# intc186

80186-compatible interrupt controller (master mode, non-cascaded subset) for the Zet co-processor, a Wishbone slave in the I/O decode window 0xFF20–0xFF3E. It takes the place of the stub slave on switch port 2 and replaces the hard-wired INT0 vector logic in the top level. It synchronises seven request sources, arbitrates them by programmable priority, drives `intr_o` to the CPU, and supplies the vector on acknowledge. It also tracks in-service state until software issues an EOI.

## Interface
- `SPUR_VEC`, 8'h07: vector returned when an acknowledge finds no eligible request.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_adr_i` in 4: word offset within 0xFF20–0xFF3E (0 = 0xFF20).
- `wb_dat_i` in 16: write data.
- `wb_dat_o` out 16: registered read data. Reset value 0.
- `wb_sel_i` in 2: byte lane enables.
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i` in 1 each: Wishbone cycle controls.
- `wb_ack_o` out 1: acknowledge. Reset value 0.
- `tmr_i`, `dma0_i`, `dma1_i` in 1 each: internal sources; tie to 0 until the timer and DMA blocks exist.
- `int_i` in 4: external INT3..INT0. These are asynchronous; INT0 is the Tube `~p_irq_b`.
- `inta_i` in 1: Zet `wb_tgc_o` acknowledge level.
- `intr_o` out 1: interrupt request to Zet `wb_tgc_i`. Reset value 0.
- `vec_o` out 8: vector, valid while `inta_i` is high. Reset value `SPUR_VEC`.

## Operation
- **Sources, bit positions and vectors:**
  - TMR: bit0, vector 0x08.
  - D0: bit2, vector 0x0A.
  - D1: bit3, vector 0x0B.
  - I0–I3: bits 4–7, vectors 0x0C–0x0F.
  - Bit 1 is unused and reads 0.
- **Registers by byte offset:**
  - 0x22 EOI: write only.
  - 0x24 POLL.
  - 0x26 POLLSTS.
  - 0x28 MASK.
  - 0x2A PRIMSK.
  - 0x2C INSERV.
  - 0x2E REQST: read only.
  - 0x30 INTSTS: reads 0.
  - 0x32 TCUCON, 0x34 DMA0CON, 0x36 DMA1CON: control registers for TMR, D0, D1.
  - 0x38–0x3E I0CON–I3CON.
  - All other offsets read 0 and ignore writes.
- **Control register fields:**
  - [2:0] PR: priority, 0 is highest.
  - [3] MSK.
  - [4] LTM: level-trigger mode (see Configuration).
  - Other bits read 0.
  - Reset: PR=7, MSK=1, LTM=0.
- **MASK register:** an alias of the MSK bits. Writing MASK updates every MSK bit.
- **PRIMSK register:** [2:0], reset 7. A source whose PR is greater than PRIMSK is blocked.
- **Request capture:**
  - Each source passes through a 2-flop synchroniser, then a rising-edge detector.
  - Edge mode: a REQST bit is set on a rising edge and cleared when that source is acknowledged.
  - Set has priority over clear in the same cycle.
  - `tmr_i`, `dma0_i` and `dma1_i` also pass through the synchroniser.
- **Eligibility:** a source is eligible when all of the following hold:
  - its REQST bit is 1 and MSK is 0;
  - PR ≤ PRIMSK;
  - PR is numerically less than the PR of every set INSERV bit.
- **Arbitration:** the winner is the eligible source with the lowest PR. Ties resolve in the fixed order TMR > D0 > D1 > I0 > I1 > I2 > I3.
- **intr_o:** a registered copy of "winner exists". It is forced to 0 during the cycle after an acknowledge.
- **Acknowledge** is the rising edge of `inta_i`, or a Wishbone read of POLL.
  - With a winner: latch the winner's vector into `vec_o`, set its INSERV bit, and clear its REQST bit (edge mode).
  - With no winner: `vec_o` = `SPUR_VEC`; no state change.
- **POLL / POLLSTS read value:** bit15 = winner exists, [4:0] = winner vector, otherwise 0. POLL acknowledges; POLLSTS has no side effects.
- **EOI write:**
  - [15]=1 (non-specific): clear the INSERV bit of the highest-priority in-service source.
  - [15]=0 (specific): clear the INSERV bit of the vector type in [4:0]. Types outside 0x08, 0x0A–0x0F are ignored.
- **Byte lanes on writes:** `wb_sel_i[0]` gates bits [7:0]; `wb_sel_i[1]` gates [15:8]. EOI requires both lanes.
- **Simultaneous events:**
  - An EOI clear and an ack set on the same INSERV bit: the set wins.
  - A POLL read and an `inta_i` edge in the same cycle produce a single acknowledge.
- **Reset mid-operation:** all state returns to its reset value on the next edge. `intr_o` drops and any pending Wishbone cycle is dropped without ack.

## Timing
- **Wishbone:**
  - `wb_ack_o` rises one cycle after `stb & cyc` and is a single-cycle pulse.
  - A new access is accepted only after the ack cycle.
  - Read data and side effects (POLL, EOI) take effect on the ack edge, exactly once per access.
- **Request latency:** an input rising edge sampled at clock edge N sets REQST at N+2 and `intr_o` at N+3, provided the source is eligible.
- **Acknowledge latency:** for an `inta_i` rising edge detected at edge M, `vec_o` is valid from M, and `intr_o` is low from M+1 to M+2 at minimum.
- **Re-arbitration:** `intr_o` can re-assert for the next winner no earlier than two cycles after the acknowledge.

## Configuration
- `INTC186_LEVEL_EN` defined:
  - LTM is writable.
  - With LTM=1, the REQST bit follows the synchronised level directly and is not cleared by acknowledge.
- `INTC186_LEVEL_EN` undefined:
  - LTM reads 0 and ignores writes.
  - All sources are edge-triggered; the level-mode logic is not built.

## Test plan
- **INT0 edge:** write I0CON=0x0002 (unmasked, PR=2) and pulse `int_i[0]` → REQST=0x0010 at N+2, `intr_o`=1 at N+3. Raise `inta_i` → `vec_o`=0x0C, INSERV=0x0010, REQST=0, `intr_o`=0.
- **Priority:** configure TMR PR=3 and I1 PR=1, then raise both together → I1 wins with vector 0x0D. After a specific EOI of 0x000D, TMR is delivered with vector 0x08.
- **Nesting:** with I2 in service at PR=4, an I0 request at PR=5 is blocked (`intr_o` stays 0). Non-specific EOI 0x8000 clears INSERV → `intr_o` rises for I0.
- **PRIMSK:** PRIMSK=2 and I3 PR=3 requesting → `intr_o` stays 0 and POLLSTS=0x0000. Writing PRIMSK=7 → POLLSTS=0x800F.
- **POLL:** with D0 pending (`dma0_i` pulsed, D0 unmasked at PR=0), a POLL read returns 0x800A and sets INSERV bit2. An immediate second POLL returns 0x0000.
- **Level mode (`INTC186_LEVEL_EN`):** with I0 LTM=1 and `int_i[0]` held high, ack then EOI → `intr_o` re-asserts. Dropping `int_i[0]` clears REQST within 2 cycles. Separately, asserting `rst` while `intr_o`=1 → all outputs return to reset values next edge.
